// File: rtl/pal_pkg.sv
// Shared sizing constants and plane-offset helpers for the field-programmable PAL.
package pal_pkg;

  localparam int DEF_NUM_INPUTS  = 8;
  localparam int DEF_NUM_OUTPUTS = 8;
  localparam int DEF_NUM_TERMS   = 8;

  // The AND plane sits at the bottom of the config word and the OR plane directly above it.
  localparam int AND_BASE = 0;

  function automatic int or_base(input int num_inputs, input int num_terms);
    return AND_BASE + 2 * num_inputs * num_terms;
  endfunction

  function automatic int cfg_len(input int num_inputs, input int num_outputs, input int num_terms);
    return or_base(num_inputs, num_terms) + num_terms * num_outputs;
  endfunction

  localparam int DEF_OR_BASE = or_base(DEF_NUM_INPUTS, DEF_NUM_TERMS);
  localparam int DEF_CFG_LEN = cfg_len(DEF_NUM_INPUTS, DEF_NUM_OUTPUTS, DEF_NUM_TERMS);

endpackage

// File: rtl/pal_array.sv
// Combinational AND/OR planes: product terms over true/complemented inputs, ORed per output.
module pal_array
  import pal_pkg::*;
#(
  parameter int N_IN    = DEF_NUM_INPUTS,
  parameter int N_OUT   = DEF_NUM_OUTPUTS,
  parameter int N_TERMS = DEF_NUM_TERMS,
  parameter int CFG_W   = DEF_CFG_LEN,
  parameter int OR_OFS  = DEF_OR_BASE
) (
  input  logic [CFG_W-1:0]   cfg_i,
  input  logic [N_IN-1:0]    in_i,
  output logic [N_OUT-1:0]   out_o
);

  localparam int TERM_W = 2 * N_IN;

  logic [TERM_W-1:0]  lit;
  logic [N_TERMS-1:0] term;

  // Literal vector interleaved as {~in[j], in[j]} so it lines up bit-for-bit with a term's config slice.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
    lit = '0;
    for (int j = 0; j < N_IN; j++) begin
      lit[2*j]   = in_i[j];
      lit[2*j+1] = ~in_i[j];
    end
  end

  // An empty term is forced to 0; otherwise every selected literal must be true.
  always_comb begin
    term = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      term[t] = (|cfg_i[AND_BASE + t*TERM_W +: TERM_W]) &&
                ((cfg_i[AND_BASE + t*TERM_W +: TERM_W] & ~lit) == '0);
    end
  end

  always_comb begin
    out_o = '0;
    for (int o = 0; o < N_OUT; o++) begin
      out_o[o] = |(term & cfg_i[OR_OFS + o*N_TERMS +: N_TERMS]);
    end
  end

endmodule

// File: rtl/pal_top_wrapper.sv
// PAL wrapper: serial config shift register, IO mapping and the PAL array.
// Define PAL_OUT_REG_EN to register uo_out (1-cycle latency, holds while ena=0).
module pal_top_wrapper
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
  parameter int NUM_TERMS   = DEF_NUM_TERMS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CFG_LEN = cfg_len(NUM_INPUTS, NUM_OUTPUTS, NUM_TERMS);
  localparam int OR_BASE = or_base(NUM_INPUTS, NUM_TERMS);

  if (NUM_INPUTS < 1 || NUM_INPUTS > 8 || NUM_OUTPUTS < 1 || NUM_OUTPUTS > 8) begin : g_bad_size
    $error("pal_top_wrapper: NUM_INPUTS and NUM_OUTPUTS must be in 1..8");
  end

  logic [CFG_LEN-1:0]     cfg_q, cfg_d;
  logic                   shift_en;
  logic [NUM_OUTPUTS-1:0] pal_out;
  logic [7:0]             out_pad;

  assign shift_en = ena & uio_in[1];

  always_comb begin
    cfg_d = cfg_q;
    if (shift_en) cfg_d = {uio_in[0], cfg_q[CFG_LEN-1:1]};
  end

  // NOTE: the config store is reset (unlike a RAM) because all-zero is its defined safe state: every output reads 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) cfg_q <= '0;
    else     cfg_q <= cfg_d;
  end

  pal_array #(
    .N_IN    (NUM_INPUTS),
    .N_OUT   (NUM_OUTPUTS),
    .N_TERMS (NUM_TERMS),
    .CFG_W   (CFG_LEN),
    .OR_OFS  (OR_BASE)
  ) u_array (
    .cfg_i (cfg_q),
    .in_i  (ui_in[NUM_INPUTS-1:0]),
    .out_o (pal_out)
  );

  always_comb begin
    out_pad = '0;
    out_pad[NUM_OUTPUTS-1:0] = pal_out;
  end

`ifdef PAL_OUT_REG_EN
  logic [7:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      out_q <= '0;
    else if (ena) out_q <= out_pad;
  end

  assign uo_out = out_q;
`else
  assign uo_out = out_pad;
`endif

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:2], ui_in};

endmodule

// File: tb/tb_pal_top_wrapper.sv
// Scoreboard bench for pal_top_wrapper against a literal-counting reference model of the PAL.
module tb_pal_top_wrapper;

  localparam int NI       = 8;
  localparam int NO       = 8;
  localparam int NT       = 8;
  localparam int OR_AT    = 2 * NI * NT;
  localparam int CFG_BITS = OR_AT + NT * NO;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [CFG_BITS-1:0] model_cfg;

  pal_top_wrapper dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
    end
  endtask

  // Term true iff at least one literal is selected and all selected literals hold.
  function automatic logic [7:0] model(input logic [CFG_BITS-1:0] c, input logic [7:0] x);
    logic [7:0] r;
    bit         term [NT];
    r = '0;
    for (int t = 0; t < NT; t++) begin
      int nsel = 0;
      int nsat = 0;
      for (int j = 0; j < NI; j++) begin
        if (c[16*t + 2*j])     begin nsel++; if (x[j] == 1'b1) nsat++; end
        if (c[16*t + 2*j + 1]) begin nsel++; if (x[j] == 1'b0) nsat++; end
      end
      term[t] = (nsel > 0) && (nsat == nsel);
    end
    for (int o = 0; o < NO; o++)
      for (int t = 0; t < NT; t++)
        if (c[OR_AT + 8*o + t] && term[t]) r[o] = 1'b1;
    return r;
  endfunction

  function automatic logic [CFG_BITS-1:0] gen_sparse();
    logic [CFG_BITS-1:0] c;
    c = '0;
    for (int t = 0; t < NT; t++) begin
      int k = $urandom_range(1, 3);
      for (int n = 0; n < k; n++) c[16*t + $urandom_range(0, 15)] = 1'b1;
    end
    for (int i = OR_AT; i < CFG_BITS; i++) c[i] = ($urandom_range(0, 2) == 0);
    return c;
  endfunction

  function automatic logic [CFG_BITS-1:0] gen_full();
    logic [CFG_BITS-1:0] c;
    for (int i = 0; i < CFG_BITS; i++) c[i] = 1'($urandom);
    return c;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, uo_out, e.val);
      end
    end
  end

  // The monitor pops at the next falling edge; anything left afterwards was never observed.
  task automatic drain();
    @(negedge clk);
    #1;
    check("scoreboard_drain", 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  // Called and returns just after a rising edge.
  task automatic apply(input logic [7:0] x, input string name);
`ifdef PAL_OUT_REG_EN
    exp_q.push_back('{name: {name, "_lag"}, val: model(model_cfg, ui_in)});
    ui_in = x;
    drain();
    @(posedge clk); #1;
    exp_q.push_back('{name: name, val: model(model_cfg, x)});
    drain();
    @(posedge clk); #1;
`else
    ui_in = x;
    exp_q.push_back('{name: name, val: model(model_cfg, x)});
    drain();
    @(posedge clk); #1;
`endif
  endtask

  task automatic shift_bit(input logic b);
    ena = 1'b1;
    uio_in = {6'($urandom), 1'b1, b};
    @(posedge clk); #1;
  endtask

  // pause_mode 0: shift enable low; 1: ena low with shift enable high.
  task automatic load(input logic [CFG_BITS-1:0] c, input int pause_at, input int pause_mode);
    for (int i = 0; i < CFG_BITS; i++) begin
      if (i == pause_at) begin
        for (int p = 0; p < 20; p++) begin
          ena    = (pause_mode == 0);
          uio_in = {6'($urandom), (pause_mode != 0), 1'($urandom)};
          @(posedge clk); #1;
        end
      end
      shift_bit(c[i]);
    end
    uio_in    = 8'h00;
    model_cfg = c;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    model_cfg = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic apply_rand(input int n, input string name);
    for (int k = 0; k < n; k++) apply(8'($urandom), name);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic [CFG_BITS-1:0] c;
    rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    model_cfg = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    apply_rand(4, "reset_state");

    // Random full config, then a reset pulse must clear it.
    load(gen_full(), -1, 0);
    apply_rand(4, "rand_full_cfg");
    rst_pulse();
    apply_rand(8, "after_rst_zero");
    check("after_rst_uio_oe", uio_oe, 8'h00);
    check("after_rst_uio_out", uio_out, 8'h00);

    // out0 = in0 & in1
    c = '0; c[0] = 1'b1; c[2] = 1'b1; c[OR_AT] = 1'b1;
    load(c, -1, 0);
    apply(8'h03, "and_in0_in1_hi");
    apply(8'h01, "and_in0_in1_lo");

    // out1 = ~in2
    c = '0; c[21] = 1'b1; c[OR_AT + 9] = 1'b1;
    load(c, -1, 0);
    apply(8'h00, "not_in2_hi");
    apply(8'h04, "not_in2_lo");

    // out0 = (in0 & in1) | ~in2
    c = '0; c[0] = 1'b1; c[2] = 1'b1; c[21] = 1'b1; c[OR_AT] = 1'b1; c[OR_AT + 1] = 1'b1;
    load(c, -1, 0);
    apply(8'h00, "sop_0x00");
    apply(8'h0F, "sop_0x0f");
    apply(8'h04, "sop_0x04");
    apply(8'h07, "sop_0x07");

    // Contradictory term (in0 & ~in0) and an empty term both read 0 even when selected.
    c = '0; c[0] = 1'b1; c[1] = 1'b1; c[OR_AT + 56] = 1'b1; c[OR_AT + 16 + 3] = 1'b1;
    load(c, -1, 0);
    apply_rand(4, "contradict_empty");
    apply(8'hFF, "contradict_empty_ff");
    apply(8'h00, "contradict_empty_00");

    for (int r = 0; r < 5; r++) begin
      load(gen_sparse(), -1, 0);
      apply_rand(5, "rand_sparse");
    end

    // Interrupted loads after 100 bits must equal an uninterrupted load.
    load(gen_sparse(), 100, 0);
    apply_rand(5, "pause_shift_en");
    load(gen_sparse(), 100, 1);
    apply_rand(5, "pause_ena");

    // Reset mid-load after 96 bits, then a full reload.
    for (int i = 0; i < 96; i++) shift_bit(1'($urandom));
    uio_in = 8'h00;
    #2;
    rst = 1'b1;
    model_cfg = '0;
    #1;
    check("midload_rst_async", uo_out, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    apply_rand(4, "midload_rst_zero");
    load(gen_sparse(), -1, 0);
    apply_rand(5, "reload_after_abort");

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
